// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
// The struct widths match the default ADDR_WIDTH/DATA_WIDTH of the top level.
package regfile_wb_arbiter_pkg;

  localparam int REG_IDX_BITS  = 5;
  localparam int WB_ADDR_WIDTH = 9;
  localparam int WB_DATA_WIDTH = 32;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef struct packed {
    logic                     valid;
    logic [WB_ADDR_WIDTH-1:0] addr;
    logic [WB_DATA_WIDTH-1:0] data;
    logic                     live;
  } wb_req_t;

  // Register index 0 of every hart is hardwired to zero.
  function automatic logic reg_is_zero(input logic [REG_IDX_BITS-1:0] idx);
    return (idx == '0);
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_wb_fifo.sv
// Small flop-based FIFO for load writebacks. Each entry carries a live bit
// that an address-matching invalidate clears, so stale loads drain silently.
module wb_fifo
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      push,
  input  logic [ADDR_WIDTH-1:0]     push_addr,
  input  logic [DATA_WIDTH-1:0]     push_data,
  input  logic                      pop,
  input  logic                      inv_en,
  input  logic [ADDR_WIDTH-1:0]     inv_addr,
  output wb_req_t                   head,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_WIDTH-1:0] mem_addr [DEPTH];
  logic [DATA_WIDTH-1:0] mem_data [DEPTH];
  logic [DEPTH-1:0]      live;
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic                  push_ok;
  logic                  pop_ok;

  always_comb begin
    push_ok = push && (count < CNT_W'(DEPTH));
    pop_ok  = pop && (count != '0);
  end

  always_comb begin
    head       = '0;
    head.valid = (count != '0);
    head.addr  = mem_addr[rd_ptr];
    head.data  = mem_data[rd_ptr];
    head.live  = live[rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      live   <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (inv_en && (mem_addr[i] == inv_addr)) live[i] <= 1'b0;
      end
      // A load arriving alongside a same-address ALU write is the older of the two.
      if (push_ok) begin
        mem_addr[wr_ptr] <= push_addr;
        mem_data[wr_ptr] <= push_data;
        live[wr_ptr]     <= !(inv_en && (push_addr == inv_addr));
        wr_ptr           <= wr_ptr + PTR_W'(1);
      end
      if (pop_ok) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Single write port controller for the barrel-core register file: clears it
// after reset, then merges fixed-priority ALU writes with buffered load writes.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int SIZE       = 512,
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          alu_wb_valid,
  input  logic [ADDR_WIDTH-1:0]         alu_wb_addr,
  input  logic [DATA_WIDTH-1:0]         alu_wb_data,
  input  logic                          mem_wb_valid,
  output logic                          mem_wb_ready,
  input  logic [ADDR_WIDTH-1:0]         mem_wb_addr,
  input  logic [DATA_WIDTH-1:0]         mem_wb_data,
  output logic                          ram_en,
  output logic                          ram_we,
  output logic [ADDR_WIDTH-1:0]         ram_addr,
  output logic [DATA_WIDTH-1:0]         ram_data,
  output logic                          init_done,
  output logic [$clog2(FIFO_DEPTH):0]   pending
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_WIDTH:0] CLR_END = (ADDR_WIDTH + 1)'(SIZE);

  state_t                state;
  logic [ADDR_WIDTH:0]   clr_cnt;
  wb_req_t               head;
  logic                  alu_take;
  logic                  mem_push;
  logic                  fifo_pop;

  // Valid/ready: a load transfers in any cycle where mem_wb_valid and
  // mem_wb_ready are both high; ready depends only on registered state.
  assign mem_wb_ready = init_done && (pending < CNT_W'(FIFO_DEPTH));

  always_comb begin
    alu_take = (state == RUN) && alu_wb_valid &&
               !reg_is_zero(alu_wb_addr[REG_IDX_BITS-1:0]);
    mem_push = mem_wb_valid && mem_wb_ready &&
               !reg_is_zero(mem_wb_addr[REG_IDX_BITS-1:0]);
    fifo_pop = (state == RUN) && head.valid && !alu_take;
  end

  wb_fifo #(
    .DEPTH      (FIFO_DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (mem_push),
    .push_addr (mem_wb_addr),
    .push_data (mem_wb_data),
    .pop       (fifo_pop),
    .inv_en    (alu_take),
    .inv_addr  (alu_wb_addr),
    .head      (head),
    .count     (pending)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= INIT;
      clr_cnt   <= '0;
      init_done <= 1'b0;
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_data  <= '0;
    end else begin
      case (state)
        INIT: begin
          // The counter reaching SIZE marks the cycle after the last clear write.
          if (clr_cnt < CLR_END) begin
            ram_en   <= 1'b1;
            ram_we   <= 1'b1;
            ram_addr <= clr_cnt[ADDR_WIDTH-1:0];
            ram_data <= '0;
            clr_cnt  <= clr_cnt + (ADDR_WIDTH + 1)'(1);
          end else begin
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
            init_done <= 1'b1;
            state     <= RUN;
          end
        end
        RUN: begin
          if (alu_take) begin
            ram_en   <= 1'b1;
            ram_we   <= 1'b1;
            ram_addr <= alu_wb_addr;
            ram_data <= alu_wb_data;
          end else if (fifo_pop && head.live) begin
            ram_en   <= 1'b1;
            ram_we   <= 1'b1;
            ram_addr <= head.addr;
            ram_data <= head.data;
          end else begin
            ram_en <= 1'b0;
            ram_we <= 1'b0;
          end
        end
        default: state <= INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed and randomized bench for regfile_wb_arbiter, checked cycle by cycle
// against a queue-based reference model of the write-port rules.
module tb_regfile_wb_arbiter;

  localparam int SIZE  = 512;
  localparam int AW    = 9;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int EW    = 1 + AW + DW;

  logic          clk = 1'b0;
  logic          reset;
  logic          alu_wb_valid;
  logic [AW-1:0] alu_wb_addr;
  logic [DW-1:0] alu_wb_data;
  logic          mem_wb_valid;
  logic          mem_wb_ready;
  logic [AW-1:0] mem_wb_addr;
  logic [DW-1:0] mem_wb_data;
  logic          ram_en;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_data;
  logic          init_done;
  logic [$clog2(DEPTH):0] pending;

  regfile_wb_arbiter #(
    .SIZE(SIZE), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .alu_wb_valid (alu_wb_valid),
    .alu_wb_addr  (alu_wb_addr),
    .alu_wb_data  (alu_wb_data),
    .mem_wb_valid (mem_wb_valid),
    .mem_wb_ready (mem_wb_ready),
    .mem_wb_addr  (mem_wb_addr),
    .mem_wb_data  (mem_wb_data),
    .ram_en       (ram_en),
    .ram_we       (ram_we),
    .ram_addr     (ram_addr),
    .ram_data     (ram_data),
    .init_done    (init_done),
    .pending      (pending)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: cycles since reset, queued loads {live, addr, data},
  // the write expected in the current cycle, and the expected RAM image.
  int               c;
  logic [EW-1:0]    exp_q[$];
  logic             exp_we;
  logic             exp_zero;
  logic [AW-1:0]    exp_addr;
  logic [DW-1:0]    exp_data;
  logic [DW-1:0]    model_ram [SIZE];
  logic [DW-1:0]    tb_ram    [SIZE];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                       input logic mv, input logic [AW-1:0] ma, input logic [DW-1:0] md);
    alu_wb_valid = av;
    alu_wb_addr  = aa;
    alu_wb_data  = ad;
    mem_wb_valid = mv;
    mem_wb_addr  = ma;
    mem_wb_data  = md;
  endtask

  function automatic logic [AW-1:0] rnd_addr();
    logic [3:0] hart;
    logic [4:0] idx;
    hart = 4'($urandom_range(0, 1));
    idx  = 5'($urandom_range(0, 3));
    return {hart, idx};
  endfunction

  task automatic drive_random();
    drive($urandom_range(0, 2) == 0, rnd_addr(), $urandom,
          $urandom_range(0, 1) == 1, rnd_addr(), $urandom);
  endtask

  // Check the current cycle against the model, advance the model with this
  // cycle's inputs, then move to one time unit after the next rising edge.
  task automatic cycle();
    logic          mready;
    logic          alu_take;
    logic          nxt_we;
    logic          nxt_zero;
    logic [AW-1:0] nxt_addr;
    logic [DW-1:0] nxt_data;
    logic [EW-1:0] ent;

    mready = (c >= SIZE + 1) && (exp_q.size() < DEPTH);
    check("ram_we", ram_we, exp_we);
    check("ram_en", ram_en, exp_we);
    if (exp_we || exp_zero) begin
      check("ram_addr", ram_addr, exp_addr);
      check("ram_data", ram_data, exp_data);
    end
    check("init_done", init_done, c >= SIZE + 1);
    check("mem_wb_ready", mem_wb_ready, mready);
    check("pending", pending, exp_q.size());
    if (ram_we === 1'b1) tb_ram[ram_addr] = ram_data;

    nxt_we = 1'b0; nxt_zero = 1'b0; nxt_addr = '0; nxt_data = '0;
    if (reset) begin
      c = 0;
      exp_q.delete();
      nxt_zero = 1'b1;
    end else begin
      if (c + 1 >= 1 && c + 1 <= SIZE) begin
        nxt_we = 1'b1;
        nxt_addr = AW'(c);
      end else if (c >= SIZE + 1) begin
        alu_take = alu_wb_valid && (alu_wb_addr[4:0] != 5'd0);
        if (alu_take) begin
          nxt_we = 1'b1;
          nxt_addr = alu_wb_addr;
          nxt_data = alu_wb_data;
          foreach (exp_q[i]) begin
            if (exp_q[i][DW +: AW] == alu_wb_addr) exp_q[i][EW-1] = 1'b0;
          end
        end else if (exp_q.size() > 0) begin
          ent = exp_q.pop_front();
          if (ent[EW-1]) begin
            nxt_we = 1'b1;
            nxt_addr = ent[DW +: AW];
            nxt_data = ent[DW-1:0];
          end
        end
        if (mem_wb_valid && mready && (mem_wb_addr[4:0] != 5'd0))
          exp_q.push_back({!(alu_take && (mem_wb_addr == alu_wb_addr)), mem_wb_addr, mem_wb_data});
      end
      c++;
    end
    exp_we = nxt_we; exp_zero = nxt_zero; exp_addr = nxt_addr; exp_data = nxt_data;
    if (nxt_we) model_ram[nxt_addr] = nxt_data;
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < SIZE; i++) begin
      model_ram[i] = '0;
      tb_ram[i]    = '0;
    end
    reset = 1'b1;
    drive(0, '0, '0, 0, '0, '0);
    repeat (2) @(posedge clk);
    #1;
    c = 0; exp_we = 1'b0; exp_zero = 1'b1; exp_addr = '0; exp_data = '0;

    // Clear sequence with junk on both inputs, which must be ignored.
    reset = 1'b0;
    repeat (SIZE + 1) begin
      drive_random();
      cycle();
    end
    check("init_done_at_513", init_done, 1'b1);

    // ALU write lands one cycle later.
    drive(1, 9'h021, 32'hDEADBEEF, 0, '0, '0);
    cycle();
    drive(0, '0, '0, 0, '0, '0);
    check("alu_we", ram_we, 1'b1);
    check("alu_addr", ram_addr, 9'h021);
    check("alu_data", ram_data, 32'hDEADBEEF);
    cycle();

    // x0 suppression on both paths.
    drive(1, 9'h040, 32'h1234, 0, '0, '0);
    cycle();
    drive(0, '0, '0, 1, 9'h060, 32'h5678);
    check("x0_alu_no_write", ram_we, 1'b0);
    check("x0_load_ready", mem_wb_ready, 1'b1);
    cycle();
    drive(0, '0, '0, 0, '0, '0);
    check("x0_load_pending", pending, 0);
    cycle();

    // Contention: ALU busy while four loads fill the FIFO.
    for (int i = 0; i < 4; i++) begin
      drive(1, 9'h1E1 + AW'(i), $urandom, 1, 9'h101 + AW'(i), $urandom);
      cycle();
    end
    drive(1, 9'h1E8, $urandom, 1, 9'h105, $urandom);
    check("full_pending", pending, 4);
    check("full_ready", mem_wb_ready, 1'b0);
    cycle();
    drive(0, '0, '0, 0, '0, '0);
    repeat (6) cycle();

    // Hazard: queued load to 0x085 overtaken by an ALU write.
    drive(1, 9'h1E2, $urandom, 1, 9'h085, 32'hBAD0BAD0);
    cycle();
    drive(1, 9'h085, 32'h1, 0, '0, '0);
    cycle();
    drive(0, '0, '0, 0, '0, '0);
    repeat (4) cycle();
    check("hazard_ram_085", tb_ram[9'h085], 32'h1);

    // Randomized traffic over a small address pool to provoke hazards.
    repeat (300) begin
      drive_random();
      cycle();
    end
    drive(0, '0, '0, 0, '0, '0);
    repeat (8) cycle();

    // Reset with three loads in flight.
    for (int i = 0; i < 3; i++) begin
      drive(1, 9'h1F1, $urandom, 1, 9'h0A1 + AW'(i), $urandom);
      cycle();
    end
    check("pre_reset_pending", pending, 3);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    drive(0, '0, '0, 0, '0, '0);
    check("reset_pending", pending, 0);
    check("reset_we", ram_we, 1'b0);
    cycle();
    check("restart_we", ram_we, 1'b1);
    check("restart_addr", ram_addr, 9'h000);
    repeat (SIZE) begin
      drive_random();
      cycle();
    end
    repeat (150) begin
      drive_random();
      cycle();
    end
    drive(0, '0, '0, 0, '0, '0);
    repeat (8) cycle();

    for (int i = 0; i < SIZE; i++) check("ram_image", tb_ram[i], model_ram[i]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-port controller for the barrel core's BRAM register file, which has a single write port. It clears the whole register file after reset, then shares the write port between two writeback sources. The ALU writeback has fixed priority and never stalls. The load writeback is handshaked and buffered in a small FIFO. Writes to x0 of any hart are suppressed, so x0 stays zero.

## Interface
Parameters:
- SIZE, 512: register file depth (harts × 32)
- ADDR_WIDTH, 9: register file address width; bits [4:0] are the register index
- DATA_WIDTH, 32: register width
- FIFO_DEPTH, 4: load-writeback buffer entries, power of two, ≥2

Ports:
- clk  in  1  single clock
- reset  in  1  synchronous, active-high
- alu_wb_valid  in  1  ALU writeback this cycle; no ready, always taken
- alu_wb_addr  in  ADDR_WIDTH  target {hart, reg}
- alu_wb_data  in  DATA_WIDTH  write data
- mem_wb_valid  in  1  load writeback request
- mem_wb_ready  out  1  FIFO can accept
- mem_wb_addr  in  ADDR_WIDTH  target {hart, reg}
- mem_wb_data  in  DATA_WIDTH  load data
- ram_en  out  1  to register file write enable
- ram_we  out  1  to register file write strobe
- ram_addr  out  ADDR_WIDTH  write address
- ram_data  out  DATA_WIDTH  write data
- init_done  out  1  clear sequence complete
- pending  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy

## Operation
- FSM states: INIT, RUN.
- reset → INIT with clear counter 0; the FIFO is flushed.
- INIT:
  - one zero write per cycle to addresses 0..SIZE-1.
  - mem_wb_ready=0.
  - alu_wb_valid is ignored; a valid here is an upstream protocol error.
  - After the SIZE-1 write is issued → RUN.
- RUN, suppression: a request with addr[4:0]==0 is dropped.
  - A dropped ALU request does not occupy the port.
  - A dropped load request is still handshaked, but is not enqueued.
- RUN, ALU path: a valid, non-suppressed ALU request wins the port unconditionally.
- RUN, load path:
  - Load FIFO entries are issued in arrival order, at most one per cycle.
  - An entry is issued only when no ALU request is using the port.
- Hazard rule: an accepted ALU write invalidates every FIFO entry with the same address. The ALU result is younger by construction.
  - An invalidated entry is popped without writing.
  - It costs one cycle when it reaches the head.
- Handshake:
  - Transfer occurs when mem_wb_valid && mem_wb_ready.
  - mem_wb_ready = init_done && (pending < FIFO_DEPTH), from registered state only.
  - Push and pop in the same cycle are allowed.
  - When full, ready is 0 even if a pop occurs that cycle.
- pending counts entries, including invalidated ones.

## Timing
- Reset values: ram_en=0, ram_we=0, ram_addr=0, ram_data=0, mem_wb_ready=0, init_done=0, pending=0.
- All ram_* outputs are registered.
- Clear sequence: with reset deasserted at edge 0, ram_we=1 with ram_addr=k during cycle k+1, for k=0..SIZE-1.
  - init_done=1 from cycle SIZE+1.
  - The first RUN write can appear at cycle SIZE+2.
- ALU latency: valid in cycle t → ram_we=1 in cycle t+1 with that addr/data.
- Load latency: accepted in cycle t → enqueued at the end of t.
  - Earliest write is cycle t+2, if no ALU request in t+1.
- Starvation: continuous ALU valids hold the FIFO indefinitely. This is accepted; the barrel schedule guarantees gaps.
- Reset asserted mid-operation:
  - Takes effect at the next edge; in-flight FIFO entries are lost.
  - The clear sequence restarts from 0.
- Width rules: the clear counter is ADDR_WIDTH+1 bits; FIFO pointers wrap modulo FIFO_DEPTH.

## Structure
- Shared package holds:
  - the FSM enum typedef (INIT, RUN);
  - a wb_req_t struct typedef: valid, addr, data, live bit;
  - the constant REG_IDX_BITS=5.
- Sub-module wb_fifo: synchronous FIFO with per-entry live bit and address-match invalidate input. Built on flops, since the FIFO is small.
- Top level holds the FSM, clear counter, arbitration and output register.

## Test plan
- Reset, SIZE=512:
  - 512 consecutive zero writes at addresses 0..511;
  - init_done=1 at cycle 513;
  - mem_wb_ready=0 throughout.
- ALU-only, RUN: ALU writes addr 0x021 with 0xDEADBEEF → next cycle ram_we=1, ram_addr=0x021, ram_data=0xDEADBEEF.
- ALU to addr 0x040 → no write issued. Load to 0x060 → handshake completes, pending stays 0.
- Contention: 4 loads accepted back-to-back while ALU is valid every cycle.
  - pending=4, ready=0.
  - ALU drops → loads written in order over the next 4 cycles.
- Hazard: load to 0x085 is queued, then ALU writes 0x085 with 0x1. The load entry is popped without a write, and the final ram write to 0x085 is 0x1.
- Assert reset while pending=3 → pending=0 next cycle and the clear sequence restarts at address 0.
